// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: streams one operand bit per clock (LSB first)
// through a shared logic/arithmetic slice and reports result, carry and zero.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             M,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               m_q, m_d, carry_q, carry_d;
  logic               cout_q, cout_d, zero_q, zero_d, done_q, done_d;

  // Bit slice: operands are shifted right each RUN cycle, so bit k sits at [0].
  logic ai, bi, yi, f, c_next;
  assign ai = a_q[0];
  assign bi = b_q[0];

  always_comb begin
    yi     = 1'b0;
    f      = 1'b0;
    c_next = 1'b0;
    if (m_q) begin
      unique case (sel_q)
        2'b00: f = ai & bi;
        2'b01: f = ai | bi;
        2'b10: f = ai ^ bi;
        default: f = ~ai;
      endcase
    end else begin
      unique case (sel_q)
        2'b00: yi = bi;
        2'b01: yi = ~bi;
        2'b10: yi = 1'b0;
        default: yi = 1'b1;
      endcase
      f      = ai ^ yi ^ carry_q;
      c_next = (ai & yi) | (ai & carry_q) | (yi & carry_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          m_d     = M;
          sel_d   = {s1, s0};
          // SUB and INC start with carry-in 1
          carry_d = ~M & (s1 ^ s0);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sr_d    = {f, sr_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        result_d = sr_q;
        cout_d   = ~m_q & carry_q;
        zero_d   = ~|sr_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= 1'b0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed + random bench for bit_serial_alu_ctrl against an arithmetic reference model.
module tb_bit_serial_alu_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, M, s1, s0;
  logic [W-1:0] a_in, b_in, result;
  logic         busy, done, cout, zero;

  int pass_cnt = 0;
  int total    = 0;
  logic [W-1:0] last_res  = '0;
  logic         last_cout = 1'b0;
  logic         last_zero = 1'b0;

  bit_serial_alu_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .s1(s1), .s0(s0),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Returns {cout, result} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic m, input logic [1:0] s,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    if (m) begin
      case (s)
        2'd0: r = {1'b0, a & b};
        2'd1: r = {1'b0, a | b};
        2'd2: r = {1'b0, a ^ b};
        default: r = {1'b0, ~a};
      endcase
    end else begin
      case (s)
        2'd0: r = {1'b0, a} + {1'b0, b};
        2'd1: r = {1'b0, a} + {1'b0, ~b} + 1;
        2'd2: r = {1'b0, a} + 1;
        default: r = {1'b0, a} + {1'b0, {W{1'b1}}};
      endcase
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle).
  task automatic run_op(input logic m, input logic [1:0] s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb);
    logic [W:0] exp;
    int n, busy_n;
    exp = model(m, s, a, b);
    M = m; s1 = s[1]; s0 = s[0]; a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); {M, s1, s0} = 3'($urandom);
    n = 1; busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (n == 2) check("held_during_run", result, last_res);
      if (n == 3 && disturb) begin
        start = 1'b1; a_in = ~a; b_in = ~b; {M, s1, s0} = ~{m, s};
      end
      if (n == 4) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_latency", n, W + 2);
    check("busy_cycles", busy_n, W + 1);
    check("result", result, exp[W-1:0]);
    check("cout", cout, exp[W]);
    check("zero", zero, exp[W-1:0] == '0);
    last_res = exp[W-1:0]; last_cout = exp[W]; last_zero = (exp[W-1:0] == '0);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; M = 1'b0; s1 = 1'b0; s0 = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_zero", zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // ADD 0xC8 + 0x64 = 0x12C
    run_op(1'b0, 2'b00, 8'hC8, 8'h64, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);

    run_op(1'b0, 2'b01, 8'h05, 8'h07, 1'b0); @(negedge clk);
    run_op(1'b0, 2'b01, 8'h07, 8'h07, 1'b0); @(negedge clk);
    run_op(1'b0, 2'b10, 8'hFF, 8'h00, 1'b0); @(negedge clk);
    run_op(1'b0, 2'b11, 8'h00, 8'h00, 1'b0); @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      run_op(1'b1, 2'(s), 8'hF0, 8'h3C, 1'b0);
      @(negedge clk);
    end

    // Second start mid-RUN is ignored
    run_op(1'b0, 2'b00, 8'h11, 8'h22, 1'b1);
    @(negedge clk);

    // Back-to-back: next start issued in the done cycle
    run_op(1'b0, 2'b00, 8'h80, 8'h80, 1'b0);
    run_op(1'b1, 2'b10, 8'hA5, 8'h5A, 1'b0);
    run_op(1'b0, 2'b01, 8'h10, 8'h01, 1'b0);
    @(negedge clk);

    // Reset held 2 cycles mid-RUN discards the operation
    M = 1'b0; s1 = 1'b0; s0 = 1'b0; a_in = 8'h12; b_in = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("rst_run_no_done", saw_done, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_result", result, 0);
    check("rst_run_cout", cout, 0);
    check("rst_run_zero", zero, 0);
    last_res = '0; last_cout = 1'b0; last_zero = 1'b0;

    // Slice table sweep on bit 0
    for (int k = 0; k < 32; k++) begin
      logic [4:0] v;
      v = 5'(k);
      run_op(v[4], v[3:2], {7'b0, v[1]}, {7'b0, v[0]}, 1'b0);
      @(negedge clk);
    end

    // Random operations
    for (int k = 0; k < 30; k++) begin
      run_op(1'($urandom), 2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
